math_adder_seq_reducer: RTL and testbench
=========================================

# math_adder_seq_reducer

Time-multiplexed reduction controller. It accepts a vector of C N-bit operands over a valid/ready handshake and sums them serially through a single shared `math_adder_carry_lookahead` instance, one operand per cycle. It presents the registered sum and an overflow flag on a valid/ready output. It is the area-optimised alternative to the combinational adder tree, for datapaths that can tolerate C cycles of latency.

## Interface
- `N`, default 16: operand and sum width in bits.
- `C`, default 10: operands per vector; C ≥ 1.
- `i_clk`  in  1  clock.
- `i_rst`  in  1  reset, synchronous, active-high; one clock domain.
- `i_valid`  in  1  input vector valid.
- `o_ready`  out  1  block can accept a vector; equals state==IDLE and is 0 while `i_rst` is high.
- `i_numbers`  in  N × [0:C-1] unpacked  operand vector, sampled only on accept.
- `i_abort`  in  1  discard the in-flight vector.
- `o_valid`  out  1  result valid (registered).
- `i_ready`  in  1  consumer accepts the result.
- `o_sum`  out  N  sum of all C operands, modulo 2^N (registered).
- `o_overflow`  out  1  set if any partial add produced a carry-out (registered).
- `o_busy`  out  1  state != IDLE.

## Operation
- States:
  - IDLE → ACCUM when accept (`i_valid && o_ready`) and C > 1.
  - IDLE → DONE when accept and C == 1.
  - ACCUM → DONE when the add using index C-1 completes.
  - DONE → IDLE on `o_valid && i_ready`.
- On accept:
  - Capture `i_numbers` into a C×N operand register.
  - Load the accumulator with operand 0.
  - Clear the overflow flag.
  - Set the index to 1.
- ACCUM, each cycle:
  - accumulator ← CLA(accumulator, operand[index], carry-in 0).
  - overflow ← overflow | CLA carry-out.
  - index++.
- DONE:
  - `o_sum` = accumulator and `o_overflow` = flag; both hold stable until the handshake.
  - `i_numbers`/`i_valid` are ignored.
- Arithmetic: wrap-around modulo 2^N. No saturation. `o_overflow` is sticky for the current vector only.
- Index counter width is max(1, $clog2(C)). The index never exceeds C-1.
- `i_abort`:
  - In ACCUM or DONE, return to IDLE next cycle; the result is dropped and `o_valid` falls.
  - In IDLE, no effect.
  - Abort together with an accept in IDLE: the accept wins.
  - In DONE, abort with `o_valid && i_ready`: the transfer completes; the result counts as delivered.
- Reset mid-operation: next cycle all state is cleared. The in-flight vector is lost and no `o_valid` is produced.

## Timing
- Reset values: `o_valid`=0, `o_sum`=0, `o_overflow`=0, `o_busy`=0, `o_ready`=0 during reset. State IDLE; `o_ready`=1 the first cycle after `i_rst` deasserts.
- Accept in cycle 0 → `o_valid` first high in cycle C (all C ≥ 1).
- Output handshake in cycle T → IDLE and `o_ready`=1 in cycle T+1.
- No same-cycle output-handshake/input-accept overlap. Peak throughput is one vector per C+1 cycles.
- CLA path is accumulator → CLA → accumulator in a single cycle; no multicycle paths.

## Structure
- Package `math_adder_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, ACCUM, DONE} reducer_state_t`.
  - The helper for the index width.
- One sub-module instance: `math_adder_carry_lookahead #(N)`, with `i_c` tied to 0.
- The operand store is plain registers, not a RAM.
- Target size is about 150 lines of RTL.

## Test plan
All scenarios use N=16, C=10 unless stated.
- Basic sum: operands 1..10, accept in cycle 0, `i_ready`=1 → `o_valid` in cycle 10, `o_sum`=55 (0x0037), `o_overflow`=0. `o_ready`=1 in cycle 11.
- Wrap and overflow: ten operands of 0xFFFF → `o_sum`=0xFFF6, `o_overflow`=1.
- Backpressure: hold `i_ready`=0 for 5 cycles after `o_valid` rises.
  - During the stall, `o_sum`/`o_overflow` stay stable, `o_ready`=0, and a new `i_valid` is ignored.
  - On release, exactly one transfer occurs.
- Abort, then recover:
  - Assert `i_abort` in cycle 4 → `o_busy`=0 in cycle 5; no `o_valid` ever appears for the aborted vector.
  - Then send operands 0,2,…,18 → `o_sum`=90.
- Reset mid-operation: assert `i_rst` in cycle 5 of an accumulation → all outputs are at reset values next cycle. A following vector 1..10 yields 55 with correct latency.
- Back-to-back and C=1:
  - Two vectors, with the second accepted in cycle 11 → results in cycles 10 and 21.
  - Separate C=1 build: operand 0x1234 → `o_sum`=0x1234, `o_valid` in cycle 1.

Source files
------------

// File: rtl/math_adder_pkg.sv
// Shared types and sizing helpers for the serial adder reducer.
package math_adder_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} reducer_state_t;

  // Width of an index that can address c entries, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned c);
    return (c > 1) ? $clog2(c) : 1;
  endfunction

endpackage

// File: rtl/math_adder_carry_lookahead.sv
// N-bit adder built from generate/propagate terms with a carry-in and carry-out.
module math_adder_carry_lookahead #(
  parameter int unsigned N = 16
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_c,
  output logic [N-1:0] o_sum,
  output logic         o_c
);

  logic [N-1:0] w_g;
  logic [N-1:0] w_p;
  logic [N:0]   w_carry;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  // Carry recurrence; synthesis flattens this into lookahead logic.
  always_comb begin
    w_carry    = '0;
    w_carry[0] = i_c;
    for (int i = 0; i < int'(N); i++) begin
      w_carry[i+1] = w_g[i] | (w_p[i] & w_carry[i]);
    end
  end

  assign o_sum = w_p ^ w_carry[N-1:0];
  assign o_c   = w_carry[N];

endmodule

// File: rtl/math_adder_seq_reducer.sv
// Serial reduction of C operands through one shared adder, one operand per cycle,
// with a valid/ready input handshake and a registered valid/ready result.
module math_adder_seq_reducer
  import math_adder_pkg::*;
#(
  parameter int unsigned N = 16,
  parameter int unsigned C = 10
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [N-1:0] i_numbers [0:C-1],
  input  logic         i_abort,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [N-1:0] o_sum,
  output logic         o_overflow,
  output logic         o_busy
);

  localparam int unsigned     IW       = idx_width(C);
  localparam logic [IW-1:0]   LAST_IDX = IW'(C - 1);
  localparam logic [IW-1:0]   FIRST_IDX = IW'((C > 1) ? 1 : 0);

  reducer_state_t r_state;
  reducer_state_t w_next_state;

  logic [N-1:0]  r_ops [0:C-1];
  logic [N-1:0]  r_acc;
  logic          r_ovf;
  logic          r_valid;
  logic [IW-1:0] r_idx;

  logic [N-1:0]  w_operand;
  logic [N-1:0]  w_add_sum;
  logic          w_add_cout;
  logic          w_accept;
  logic          w_deliver;
  logic          w_last;

  assign w_accept  = i_valid && o_ready;
  assign w_deliver = r_valid && i_ready;
  assign w_last    = (r_idx == LAST_IDX);

  generate
    if (C > 1) begin : g_multi
      assign w_operand = r_ops[r_idx];
    end else begin : g_single
      assign w_operand = r_ops[0];
    end
  endgenerate

  math_adder_carry_lookahead #(.N(N)) u_cla (
    .i_a   (r_acc),
    .i_b   (w_operand),
    .i_c   (1'b0),
    .o_sum (w_add_sum),
    .o_c   (w_add_cout)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Abort loses to accept in IDLE and to a completing transfer in DONE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (C > 1) w_next_state = ACCUM;
          else       w_next_state = DONE;
        end
      end
      ACCUM: begin
        if (i_abort)     w_next_state = IDLE;
        else if (w_last) w_next_state = DONE;
      end
      DONE: begin
        if (w_deliver || i_abort) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < int'(C); i++) r_ops[i] <= '0;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
      r_valid <= 1'b0;
      r_idx   <= '0;
    end else begin
      if (w_accept) begin
        for (int i = 0; i < int'(C); i++) r_ops[i] <= i_numbers[i];
        r_acc <= i_numbers[0];
        r_ovf <= 1'b0;
        r_idx <= FIRST_IDX;
      end else if (r_state == ACCUM && !i_abort) begin
        r_acc <= w_add_sum;
        r_ovf <= r_ovf | w_add_cout;
        if (!w_last) r_idx <= IW'(r_idx + 1'b1);
      end
      r_valid <= (w_next_state == DONE);
    end
  end

  assign o_ready    = (r_state == IDLE) && !i_rst;
  assign o_busy     = (r_state != IDLE);
  assign o_valid    = r_valid;
  assign o_sum      = r_acc;
  assign o_overflow = r_ovf;

endmodule

// File: tb/tb_math_adder_seq_reducer.sv
// Randomized self-checking bench for the serial adder reducer (C=10 and C=1 builds).
module tb_math_adder_seq_reducer;

  localparam int unsigned N = 16;
  localparam int unsigned C = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         valid;
  logic         abort;
  logic         rdy;
  logic [N-1:0] nums [0:C-1];
  logic         o_ready, o_valid, o_overflow, o_busy;
  logic [N-1:0] o_sum;

  logic         v1, ab1, rdy1;
  logic [N-1:0] nums1 [0:0];
  logic         o_ready1, o_valid1, o_overflow1, o_busy1;
  logic [N-1:0] o_sum1;

  math_adder_seq_reducer #(.N(N), .C(C)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(o_ready),
    .i_numbers(nums), .i_abort(abort), .o_valid(o_valid), .i_ready(rdy),
    .o_sum(o_sum), .o_overflow(o_overflow), .o_busy(o_busy)
  );

  math_adder_seq_reducer #(.N(N), .C(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_valid(v1), .o_ready(o_ready1),
    .i_numbers(nums1), .i_abort(ab1), .o_valid(o_valid1), .i_ready(rdy1),
    .o_sum(o_sum1), .o_overflow(o_overflow1), .o_busy(o_busy1)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [N-1:0] vec [0:C-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: integer sum wrapped mod 2^N; overflow if any running partial sum crosses 2^N.
  function automatic int unsigned model_sum();
    longint unsigned t = 0;
    for (int i = 0; i < int'(C); i++) t += longint'(vec[i]);
    return int'(t % 65536);
  endfunction

  function automatic int unsigned model_ovf();
    longint unsigned acc = longint'(vec[0]);
    int unsigned ov = 0;
    for (int i = 1; i < int'(C); i++) begin
      acc += longint'(vec[i]);
      if (acc > 65535) begin
        ov  = 1;
        acc -= 65536;
      end
    end
    return ov;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present vec for one cycle; on return the bench sits in cycle 1 after the accept.
  task automatic send(input logic with_abort);
    int w = 0;
    while (!o_ready && w < 50) begin
      step();
      w++;
    end
    check("ready_before_send", 32'(o_ready), 32'd1);
    nums  = vec;
    valid = 1'b1;
    abort = with_abort;
    step();
    valid = 1'b0;
    abort = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 1;
    while (!o_valid && cyc < int'(C) + 20) begin
      step();
      cyc++;
    end
    check("valid_timeout", 32'(o_valid), 32'd1);
  endtask

  task automatic expect_result(input string tag);
    int cyc;
    rdy = 1'b1;
    wait_valid(cyc);
    check({tag, "_latency"}, 32'(cyc), 32'(C));
    check({tag, "_sum"}, 32'(o_sum), 32'(model_sum()));
    check({tag, "_ovf"}, 32'(o_overflow), 32'(model_ovf()));
    step();
    check({tag, "_valid_drop"}, 32'(o_valid), 32'd0);
    check({tag, "_ready_after"}, 32'(o_ready), 32'd1);
  endtask

  initial begin
    int cyc, cyc2, xfers, seen;
    rst = 1'b1; valid = 1'b0; abort = 1'b0; rdy = 1'b1;
    v1 = 1'b0; ab1 = 1'b0; rdy1 = 1'b1; nums1[0] = '0;
    for (int i = 0; i < int'(C); i++) nums[i] = '0;
    step(); step(); step();

    // Reset values
    check("rst_ready", 32'(o_ready), 32'd0);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_sum", 32'(o_sum), 32'd0);
    check("rst_ovf", 32'(o_overflow), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    rst = 1'b0;
    step();
    check("ready_after_rst", 32'(o_ready), 32'd1);

    // Basic 1..10
    for (int i = 0; i < int'(C); i++) vec[i] = 16'(i + 1);
    send(1'b0);
    check("basic_busy", 32'(o_busy), 32'd1);
    check("basic_ready_low", 32'(o_ready), 32'd0);
    expect_result("basic");
    check("basic_sum_const", 32'(model_sum()), 32'd55);

    // Wrap and overflow
    for (int i = 0; i < int'(C); i++) vec[i] = 16'hFFFF;
    send(1'b0);
    rdy = 1'b1;
    wait_valid(cyc);
    check("wrap_sum", 32'(o_sum), 32'hFFF6);
    check("wrap_ovf", 32'(o_overflow), 32'd1);
    step();

    // Randomized vectors: full range, small (no overflow) and near-max
    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < int'(C); i++) begin
        case (t % 3)
          0: vec[i] = 16'($urandom);
          1: vec[i] = 16'($urandom_range(0, 16'h0FFF));
          default: vec[i] = 16'($urandom_range(16'hF000, 16'hFFFF));
        endcase
      end
      send(1'b0);
      expect_result("rand");
    end

    // Backpressure: result holds, new input ignored, exactly one transfer on release
    for (int i = 0; i < int'(C); i++) vec[i] = 16'($urandom);
    rdy = 1'b0;
    send(1'b0);
    wait_valid(cyc);
    check("bp_latency", 32'(cyc), 32'(C));
    for (int k = 0; k < 5; k++) begin
      valid = 1'b1;
      for (int i = 0; i < int'(C); i++) nums[i] = 16'($urandom);
      step();
      check("bp_sum_hold", 32'(o_sum), 32'(model_sum()));
      check("bp_ovf_hold", 32'(o_overflow), 32'(model_ovf()));
      check("bp_ready_low", 32'(o_ready), 32'd0);
      check("bp_valid_hold", 32'(o_valid), 32'd1);
    end
    valid = 1'b0;
    rdy   = 1'b1;
    xfers = 0;
    for (int k = 0; k < 4; k++) begin
      if (o_valid && rdy) xfers++;
      step();
    end
    check("bp_one_xfer", 32'(xfers), 32'd1);
    check("bp_idle_after", 32'(o_busy), 32'd0);

    // Abort in cycle 4, then recover
    for (int i = 0; i < int'(C); i++) vec[i] = 16'($urandom);
    send(1'b0);
    step(); step(); step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_busy", 32'(o_busy), 32'd0);
    check("abort_ready", 32'(o_ready), 32'd1);
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      if (o_valid) seen = 1;
      step();
    end
    check("abort_no_valid", 32'(seen), 32'd0);
    for (int i = 0; i < int'(C); i++) vec[i] = 16'(2 * i);
    send(1'b0);
    rdy = 1'b1;
    wait_valid(cyc);
    check("abort_rec_lat", 32'(cyc), 32'(C));
    check("abort_rec_sum", 32'(o_sum), 32'd90);
    step();

    // Abort together with accept in IDLE: accept wins
    for (int i = 0; i < int'(C); i++) vec[i] = 16'($urandom);
    send(1'b1);
    expect_result("abort_accept");

    // Abort in DONE without handshake drops the result
    rdy = 1'b0;
    send(1'b0);
    wait_valid(cyc);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_done_valid", 32'(o_valid), 32'd0);
    check("abort_done_busy", 32'(o_busy), 32'd0);
    rdy = 1'b1;

    // Abort in DONE with handshake: transfer completes
    send(1'b0);
    wait_valid(cyc);
    check("abort_hs_sum", 32'(o_sum), 32'(model_sum()));
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_hs_valid", 32'(o_valid), 32'd0);
    check("abort_hs_ready", 32'(o_ready), 32'd1);

    // Reset mid-operation
    for (int i = 0; i < int'(C); i++) vec[i] = 16'($urandom);
    send(1'b0);
    step(); step(); step(); step();
    rst = 1'b1;
    step();
    check("midrst_valid", 32'(o_valid), 32'd0);
    check("midrst_sum", 32'(o_sum), 32'd0);
    check("midrst_ovf", 32'(o_overflow), 32'd0);
    check("midrst_busy", 32'(o_busy), 32'd0);
    check("midrst_ready", 32'(o_ready), 32'd0);
    rst = 1'b0;
    step();
    check("midrst_ready_after", 32'(o_ready), 32'd1);
    for (int i = 0; i < int'(C); i++) vec[i] = 16'(i + 1);
    send(1'b0);
    expect_result("midrst_rec");

    // Back-to-back: second accept in cycle 11, results in cycles 10 and 21
    for (int i = 0; i < int'(C); i++) vec[i] = 16'($urandom);
    rdy = 1'b1;
    send(1'b0);
    wait_valid(cyc);
    check("b2b_first_cycle", 32'(cyc), 32'd10);
    check("b2b_first_sum", 32'(o_sum), 32'(model_sum()));
    step();
    for (int i = 0; i < int'(C); i++) vec[i] = 16'($urandom);
    send(1'b0);
    wait_valid(cyc2);
    check("b2b_second_cycle", 32'(cyc + 1 + cyc2), 32'd21);
    check("b2b_second_sum", 32'(o_sum), 32'(model_sum()));
    check("b2b_second_ovf", 32'(o_overflow), 32'(model_ovf()));
    step();

    // C=1 build
    for (int t = 0; t < 4; t++) begin
      logic [N-1:0] op;
      op = (t == 0) ? 16'h1234 : 16'($urandom);
      check("c1_ready", 32'(o_ready1), 32'd1);
      nums1[0] = op;
      v1 = 1'b1;
      step();
      v1 = 1'b0;
      check("c1_valid", 32'(o_valid1), 32'd1);
      check("c1_sum", 32'(o_sum1), 32'(op));
      check("c1_ovf", 32'(o_overflow1), 32'd0);
      step();
      check("c1_valid_drop", 32'(o_valid1), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
